hazard_mc: RTL and testbench

//  Parametrised hazard unit for the 5-stage MIPS pipeline (F/D/E/M/W).

---
 rtl/hazard_mc.sv | 159 +++++++++++++++
 tb/tb_hazard_mc.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_mc.sv
// Hazard unit for the 5-stage pipeline: forwarding, stalls, flushes,
// multi-cycle unit handshake tracking and exception/ERET redirect.
module hazard_mc #(
  parameter int          REG_AW     = 5,
  parameter int          MC_N       = 2,
  parameter int          CNT_W      = 16,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic              branchD,
  input  logic              jrD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic [REG_AW-1:0] writeregE,
  input  logic              regwriteE,
  input  logic              memtoregE,
  input  logic [MC_N-1:0]   mc_opE,
  input  logic [MC_N-1:0]   mc_ready,
  input  logic [REG_AW-1:0] writeregM,
  input  logic              regwriteM,
  input  logic              memtoregM,
  input  logic              exc_validM,
  input  logic              exc_eretM,
  input  logic [31:0]       epcM,
  input  logic [REG_AW-1:0] writeregW,
  input  logic              regwriteW,
  output logic [1:0]        forwardaD,
  output logic [1:0]        forwardbD,
  output logic [1:0]        forwardaE,
  output logic [1:0]        forwardbE,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              stallW,
  output logic              flushF,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              flushW,
  output logic [MC_N-1:0]   mc_start,
  output logic              mc_abort,
  output logic              pc_redirect,
  output logic [31:0]       newPC,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [MC_N-1:0] MC_ONE = MC_N'(1);

  // one bit per channel: 0 = IDLE, 1 = BUSY
  logic [MC_N-1:0]  busy_q, busy_d;
  logic [MC_N-1:0]  mc_sel;
  logic [MC_N-1:0]  ch_stall;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             lw, bj, hit_e, hit_m;

  function automatic logic [1:0] fwd(
    input logic [REG_AW-1:0] src,
    input logic              wr_m,
    input logic [REG_AW-1:0] dst_m,
    input logic              wr_w,
    input logic [REG_AW-1:0] dst_w
  );
    logic [1:0] r;
    r = 2'b00;
    if (src != '0) begin
      if (wr_m && dst_m == src)      r = 2'b10;
      else if (wr_w && dst_w == src) r = 2'b01;
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // lowest set bit of mc_opE is the only op serviced
  always_comb begin
    mc_sel = mc_opE & (~mc_opE + MC_ONE);
    busy_d = busy_q;
    for (int i = 0; i < MC_N; i++) begin
      if (!busy_q[i] && mc_sel[i])     busy_d[i] = 1'b1;
      else if (busy_q[i] && mc_ready[i]) busy_d[i] = 1'b0;
    end
    if (exc_validM) busy_d = '0;
  end

  always_comb begin
    forwardaD = fwd(rsD, regwriteM, writeregM, regwriteW, writeregW);
    forwardbD = fwd(rtD, regwriteM, writeregM, regwriteW, writeregW);
    forwardaE = fwd(rsE, regwriteM, writeregM, regwriteW, writeregW);
    forwardbE = fwd(rtE, regwriteM, writeregM, regwriteW, writeregW);

    lw = memtoregE && writeregE != '0 &&
         (writeregE == rsD || writeregE == rtD);

    hit_e = 1'b0;
    hit_m = 1'b0;
    if (branchD) begin
      hit_e = writeregE == rsD || writeregE == rtD;
      hit_m = writeregM == rsD || writeregM == rtD;
    end else if (jrD) begin
      hit_e = writeregE == rsD;
      hit_m = writeregM == rsD;
    end
    bj = (regwriteE && writeregE != '0 && hit_e) ||
         (memtoregM && writeregM != '0 && hit_m);

    ch_stall = (~busy_q & mc_sel) | (busy_q & ~mc_ready);

    stallE      = |ch_stall;
    stallD      = stallE | lw | bj;
    stallF      = stallD;
    stallM      = 1'b0;
    stallW      = 1'b0;
    flushF      = 1'b0;
    flushD      = 1'b0;
    flushE      = (lw | bj) & ~stallE;
    flushM      = 1'b0;
    flushW      = 1'b0;
    mc_start    = ~busy_q & mc_sel;
    mc_abort    = 1'b0;
    pc_redirect = 1'b0;
    newPC       = 32'h0;

    if (exc_validM) begin
      stallF      = 1'b0;
      stallD      = 1'b0;
      stallE      = 1'b0;
      flushF      = 1'b1;
      flushD      = 1'b1;
      flushE      = 1'b1;
      flushM      = 1'b1;
      flushW      = 1'b1;
      mc_start    = '0;
      mc_abort    = |busy_q;
      pc_redirect = 1'b1;
      newPC       = exc_eretM ? epcM : EXC_VECTOR;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stallF && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_mc.sv
// Directed-vector bench for hazard_mc (counter width 4 to reach saturation).
module tb_hazard_mc;

  logic        clk = 1'b0;
  logic        resetn;
  logic [4:0]  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic        branchD, jrD, regwriteE, memtoregE;
  logic [1:0]  mc_opE, mc_ready;
  logic        regwriteM, memtoregM, exc_validM, exc_eretM, regwriteW;
  logic [31:0] epcM;
  logic [1:0]  forwardaD, forwardbD, forwardaE, forwardbE;
  logic        stallF, stallD, stallE, stallM, stallW;
  logic        flushF, flushD, flushE, flushM, flushW;
  logic [1:0]  mc_start;
  logic        mc_abort, pc_redirect;
  logic [31:0] newPC;
  logic [3:0]  stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_mc #(.REG_AW(5), .MC_N(2), .CNT_W(4),
              .EXC_VECTOR(32'hBFC00380)) dut (
    .clk(clk), .resetn(resetn),
    .rsD(rsD), .rtD(rtD), .branchD(branchD), .jrD(jrD),
    .rsE(rsE), .rtE(rtE), .writeregE(writeregE),
    .regwriteE(regwriteE), .memtoregE(memtoregE),
    .mc_opE(mc_opE), .mc_ready(mc_ready),
    .writeregM(writeregM), .regwriteM(regwriteM),
    .memtoregM(memtoregM), .exc_validM(exc_validM),
    .exc_eretM(exc_eretM), .epcM(epcM),
    .writeregW(writeregW), .regwriteW(regwriteW),
    .forwardaD(forwardaD), .forwardbD(forwardbD),
    .forwardaE(forwardaE), .forwardbE(forwardbE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .stallM(stallM), .stallW(stallW),
    .flushF(flushF), .flushD(flushD), .flushE(flushE),
    .flushM(flushM), .flushW(flushW),
    .mc_start(mc_start), .mc_abort(mc_abort),
    .pc_redirect(pc_redirect), .newPC(newPC),
    .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clr();
    rsD = 0; rtD = 0; branchD = 0; jrD = 0;
    rsE = 0; rtE = 0; writeregE = 0;
    regwriteE = 0; memtoregE = 0;
    mc_opE = 0; mc_ready = 0;
    writeregM = 0; regwriteM = 0; memtoregM = 0;
    exc_validM = 0; exc_eretM = 0; epcM = 0;
    writeregW = 0; regwriteW = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    resetn = 1'b0;
    #12;
    chk("rst_cnt", 32'(stall_cnt), 0);
    chk("rst_stall", {stallF, stallD, stallE, stallM, stallW}, 0);
    chk("rst_flush", {flushF, flushD, flushE, flushM, flushW}, 0);
    chk("rst_pc", newPC, 0);
    chk("rst_fwd", {forwardaD, forwardbD, forwardaE, forwardbE}, 0);
    chk("rst_mc", {mc_start, mc_abort, pc_redirect}, 0);
    resetn = 1'b1;
    tick();

    // load-use: lw $2 in E, D reads $2
    memtoregE = 1; regwriteE = 1; writeregE = 2; rsD = 2;
    #1;
    chk("lw_stall", {stallF, stallD, stallE, flushE}, 4'b1101);
    chk("lw_nomisc", {flushF, flushD, flushM, flushW}, 0);
    tick();
    clr();
    rsD = 2; rsE = 2; writeregM = 2; regwriteM = 1; memtoregM = 1;
    #1;
    chk("lw_fwdM", 32'(forwardaE), 2'b10);
    chk("lw_bubble", {stallF, flushE}, 0);
    tick();
    clr();
    rsE = 2; writeregW = 2; regwriteW = 1;
    #1;
    chk("lw_fwdW", 32'(forwardaE), 2'b01);
    writeregM = 2; regwriteM = 1;
    #1;
    chk("fwd_prio", 32'(forwardaE), 2'b10);
    clr();
    regwriteM = 1; regwriteW = 1; writeregW = 5; rtD = 5;
    #1;
    chk("fwd_zero", {forwardaD, forwardaE, forwardbE}, 0);
    chk("fwd_bD", 32'(forwardbD), 2'b01);

    // branch / jr
    clr();
    branchD = 1; rsD = 3; regwriteE = 1; writeregE = 3;
    #1;
    chk("beq_stall", {stallD, flushE}, 2'b11);
    writeregE = 0;
    #1;
    chk("beq_r0", {stallD, flushE}, 0);
    clr();
    branchD = 1; rsD = 7; rtD = 3; regwriteE = 1; writeregE = 3;
    #1;
    chk("beq_rt", 32'(stallD), 1);
    clr();
    jrD = 1; rsD = 7; rtD = 3; regwriteE = 1; writeregE = 3;
    #1;
    chk("jr_rt", 32'(stallD), 0);
    clr();
    jrD = 1; rsD = 4; memtoregM = 1; writeregM = 4;
    #1;
    chk("jr_ldM", {stallF, stallD, flushE}, 3'b111);
    tick();

    // div, ready after 8 stall cycles
    clr();
    mc_opE = 2'b01;
    #1;
    chk("div_start", {mc_start, stallE, stallD, stallF, flushE}, 6'b011110);
    tick();
    for (int k = 1; k < 8; k++) begin
      chk("div_busy", {mc_start, stallE}, 3'b001);
      tick();
    end
    mc_ready = 2'b01;
    #1;
    chk("div_ready", {mc_start, stallE, stallF}, 0);
    tick();
    mc_opE = 2'b10; mc_ready = 0;
    #1;
    chk("mul_start", {mc_start, stallE}, 3'b101);
    tick();
    chk("mul_busy", {mc_start, stallE}, 3'b001);
    mc_ready = 2'b10;
    #1;
    chk("mul_ready", 32'(stallE), 0);
    tick();

    // ready while idle is ignored; lowest op bit wins
    clr();
    mc_ready = 2'b01;
    #1;
    chk("rdy_idle", 32'(stallE), 0);
    tick();
    mc_ready = 0; mc_opE = 2'b11;
    #1;
    chk("mc_lowbit", 32'(mc_start), 2'b01);
    tick();

    // exception while div busy
    mc_opE = 2'b01;
    exc_validM = 1;
    memtoregE = 1; writeregE = 2; rsD = 2;
    #1;
    chk("exc_flush", {flushF, flushD, flushE, flushM, flushW}, 5'h1f);
    chk("exc_stall", {stallF, stallD, stallE, stallM, stallW}, 0);
    chk("exc_abort", {mc_abort, pc_redirect, mc_start}, 4'b1100);
    chk("exc_pc", newPC, 32'hBFC00380);
    tick();
    clr();
    #1;
    chk("exc_idle", {mc_abort, stallE, pc_redirect, newPC}, 0);
    mc_opE = 2'b01;
    #1;
    chk("exc_restart", 32'(mc_start), 2'b01);
    tick();

    // reset mid-busy
    resetn = 1'b0;
    exc_validM = 1;
    #1;
    chk("rstbusy_cnt", 32'(stall_cnt), 0);
    chk("rstbusy_abort", 32'(mc_abort), 0);
    exc_validM = 0;
    resetn = 1'b1;
    #1;
    chk("rstbusy_idle", {mc_start, stallE}, 3'b011);
    tick();

    // ERET, channel 0 still busy from the restart
    clr();
    mc_opE = 2'b01;
    exc_validM = 1; exc_eretM = 1; epcM = 32'h80001234;
    #1;
    chk("eret_pc", newPC, 32'h80001234);
    chk("eret_ctl", {pc_redirect, mc_abort, stallF, stallD, stallE}, 5'b11000);
    tick();
    clr();

    // stall_cnt saturation
    resetn = 1'b0;
    #1;
    resetn = 1'b1;
    memtoregE = 1; writeregE = 6; rtD = 6;
    for (int k = 0; k < 5; k++) tick();
    chk("cnt_5", 32'(stall_cnt), 5);
    for (int k = 0; k < 15; k++) tick();
    chk("cnt_sat", 32'(stall_cnt), 15);
    clr();
    tick();
    chk("cnt_hold", 32'(stall_cnt), 15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
